// File: rtl/digest_serializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : digest_serializer_if
//  Purpose  : Digest capture and word-stream bundle for digest_serializer.
//             The master modport is the serializer side. The slave modport is
//             the hash core and consumer side.
//  Revision : 1.0  initial release
// ============================================================================
interface digest_serializer_if #(
    parameter int DIG_W = 512,
    parameter int OUT_W = 32
);
    logic [DIG_W-1:0] dig_in;
    logic             dig_valid;
    logic [OUT_W-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             dout_last;

    modport master (
        input  dig_in,
        input  dig_valid,
        input  dout_ready,
        output dout,
        output dout_valid,
        output dout_last
    );

    modport slave (
        output dig_in,
        output dig_valid,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  dout_last
    );
endinterface
`default_nettype wire

// File: rtl/digest_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : digest_serializer
//  Purpose  : Captures a DIG_W-bit SHA3-512 digest on the rising edge of the
//             hash-complete level. Streams it least-significant word first as
//             OUT_W-bit words over valid/ready. Flags any digest that arrives
//             while a frame is still in flight.
//  Revision : 1.0  initial release
// ============================================================================
module digest_serializer #(
    parameter int DIG_W = 512,   // must be a multiple of OUT_W
    parameter int OUT_W = 32
) (
    input  wire                  clk,
    input  wire                  rst_b,
    digest_serializer_if.master  bus,
    input  wire                  clr,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);
    localparam int             NW       = DIG_W / OUT_W;
    localparam int             CW       = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(NW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q,      state_d;
    logic [CW-1:0]    cnt_q,        cnt_d;
    logic [DIG_W-1:0] shreg_q,      shreg_d;
    logic             dig_valid_q,  dig_valid_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q,  dout_last_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic             ovf_q,        ovf_d;
    logic             rise;

    // One capture per completion: the core holds its flag high for a while.
    assign rise        = bus.dig_valid & ~dig_valid_q;
    assign dig_valid_d = bus.dig_valid;

    // Next-state and registered-output logic; clr overrides everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        done_d       = 1'b0;
        ovf_d        = ovf_q;
        if (clr) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            dout_valid_d = 1'b0;
            dout_last_d  = 1'b0;
            ovf_d        = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        shreg_d      = bus.dig_in;
                        cnt_d        = '0;
                        dout_valid_d = 1'b1;
                        dout_last_d  = (LAST_CNT == '0);
                        state_d      = ST_SEND;
                    end
                end
                ST_SEND: begin
                    // A second digest mid-frame is dropped, only flagged.
                    if (rise) begin
                        ovf_d = 1'b1;
                    end
                    if (dout_valid_q && bus.dout_ready) begin
                        shreg_d = shreg_q >> OUT_W;
                        if (cnt_q == LAST_CNT) begin
                            state_d      = ST_DONE;
                            dout_valid_d = 1'b0;
                            dout_last_d  = 1'b0;
                            done_d       = 1'b1;
                        end else begin
                            cnt_d       = cnt_q + 1'b1;
                            dout_last_d = (cnt_d == LAST_CNT);
                        end
                    end
                end
                ST_DONE: begin
                    if (rise) begin
                        ovf_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shreg_q      <= '0;
            dig_valid_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            dig_valid_q  <= dig_valid_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    // The low word of the shift register is the word on offer.
    assign bus.dout       = shreg_q[OUT_W-1:0];
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign ovf            = ovf_q;
endmodule
`default_nettype wire
